// File: rtl/msdf_serializer_if.sv
// Handshake bundle between an operand producer, the MSDF serializer and the
// digit consumer (serial-serial MSDF multiplier).
//   master : producer/consumer side (drives in_*, out_ready)
//   slave  : serializer side
interface msdf_serializer_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_digit;
  logic         out_first;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_digit, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_digit, out_first, out_last
  );
endinterface

// File: rtl/msdf_serializer.sv
// msdf_serializer: takes an N-bit two's-complement fraction and streams it
// MSD-first as radix-2 signed digits, one digit per out handshake, framed
// with first/last markers for the downstream MSDF multiplier.
// Optional feature macro: MSDF_SER_FLUSH_EN -- appends DELTA zero digits to
// each frame so the consumer's online delay is drained; out_last then marks
// the final flush digit instead of data digit N-1.
`ifndef R2_ZERO
`define R2_ZERO    2'b00
`endif
`ifndef R2_POS_ONE
`define R2_POS_ONE 2'b01
`endif
`ifndef R2_NEG_ONE
`define R2_NEG_ONE 2'b11
`endif

module msdf_serializer #(
  parameter int N     = 8,
  parameter int DELTA = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  msdf_serializer_if.slave     bus,
  output logic                 busy
);

  localparam int CW = $clog2(N + DELTA + 1);
  localparam logic [CW-1:0] LAST_DATA    = CW'(N - 1);
  localparam logic [CW-1:0] LAST_DATA_M1 = CW'(N - 2);
`ifdef MSDF_SER_FLUSH_EN
  localparam logic [CW-1:0] LAST_FRAME    = CW'(N + DELTA - 1);
  localparam logic [CW-1:0] LAST_FRAME_M1 = CW'(N + DELTA - 2);
`endif

  typedef enum logic [1:0] {
`ifdef MSDF_SER_FLUSH_EN
    FLUSH = 2'd2,
`endif
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;

  state_t        state_q;
  // The sign bit goes straight into the digit register at accept time, so
  // only the N-1 magnitude bits need to be held for later digits.
  logic [N-2:0]  sreg_q;
  logic [CW-1:0] cnt_q;
  logic          out_valid_q;
  logic [1:0]    out_digit_q;
  logic          out_first_q;
  logic          out_last_q;

  logic fire;
  logic in_ready;
  logic accept;

  // A new operand can enter when idle, or on the handshake that retires the
  // final digit of the current frame (gives bubble-free back-to-back frames).
  always_comb begin
    fire     = out_valid_q & bus.out_ready;
    in_ready = (state_q == IDLE) | (fire & out_last_q);
    accept   = bus.in_valid & in_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_digit = out_digit_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q != IDLE);

  // Frame FSM with registered digit/marker outputs; outputs only move on
  // accept or on a digit handshake, so a stalled digit holds steady.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_digit_q <= `R2_ZERO;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      state_q     <= SHIFT;
      sreg_q      <= bus.in_data[N-2:0];
      cnt_q       <= '0;
      out_valid_q <= 1'b1;
      // Digit 0 carries weight -1: a set sign bit is -1, never +1.
      out_digit_q <= bus.in_data[N-1] ? `R2_NEG_ONE : `R2_ZERO;
      out_first_q <= 1'b1;
      out_last_q  <= 1'b0;
    end else if (fire) begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == LAST_DATA) begin
`ifdef MSDF_SER_FLUSH_EN
            state_q     <= FLUSH;
            cnt_q       <= cnt_q + CW'(1);
            out_digit_q <= `R2_ZERO;
            out_first_q <= 1'b0;
            out_last_q  <= (DELTA == 1);
`else
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_digit_q <= `R2_ZERO;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
`endif
          end else begin
            sreg_q      <= sreg_q << 1;
            cnt_q       <= cnt_q + CW'(1);
            out_digit_q <= sreg_q[N-2] ? `R2_POS_ONE : `R2_ZERO;
            out_first_q <= 1'b0;
`ifdef MSDF_SER_FLUSH_EN
            out_last_q  <= 1'b0;
`else
            out_last_q  <= (cnt_q == LAST_DATA_M1);
`endif
          end
        end
`ifdef MSDF_SER_FLUSH_EN
        FLUSH: begin
          if (cnt_q == LAST_FRAME) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_digit_q <= `R2_ZERO;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
          end else begin
            cnt_q       <= cnt_q + CW'(1);
            out_digit_q <= `R2_ZERO;
            out_last_q  <= (cnt_q == LAST_FRAME_M1);
          end
        end
`endif
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msdf_serializer.sv
// Directed bench for msdf_serializer (N=8, DELTA=2). Frame length follows
// MSDF_SER_FLUSH_EN: 8 data digits, plus 2 zero flush digits when defined.
`ifndef R2_ZERO
`define R2_ZERO    2'b00
`endif
`ifndef R2_POS_ONE
`define R2_POS_ONE 2'b01
`endif
`ifndef R2_NEG_ONE
`define R2_NEG_ONE 2'b11
`endif

module tb_msdf_serializer;
  localparam int N     = 8;
  localparam int DELTA = 2;
`ifdef MSDF_SER_FLUSH_EN
  localparam int FL = N + DELTA;
`else
  localparam int FL = N;
`endif
  localparam logic [1:0] Z = `R2_ZERO;
  localparam logic [1:0] P = `R2_POS_ONE;
  localparam logic [1:0] M = `R2_NEG_ONE;

  typedef struct {
    logic [7:0]        data;
    logic [0:7][1:0]   dig;   // index 0 = digit 0 (MSD)
  } vec_t;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   errors;

  msdf_serializer_if #(.N(N)) bus ();

  msdf_serializer #(.N(N), .DELTA(DELTA)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive an operand at a negedge; it is taken on the following posedge.
  task automatic accept(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    chk("accept_ready", {7'd0, bus.in_ready}, 8'd1);
    @(negedge clk);
  endtask

  // Check a whole frame digit by digit. Optional stall at digit stall_at for
  // stall_len cycles; has_next keeps the next operand offered throughout.
  task automatic stream(input vec_t v, input int stall_at, input int stall_len,
                        input logic has_next, input logic [7:0] nxt);
    logic [1:0] e;
    bus.in_valid = has_next;
    bus.in_data  = has_next ? nxt : 8'h00;
    #1;
    for (int k = 0; k < FL; k++) begin
      e = (k < N) ? v.dig[k] : Z;
      chk($sformatf("valid_%0h_d%0d", v.data, k), {7'd0, bus.out_valid}, 8'd1);
      chk($sformatf("digit_%0h_d%0d", v.data, k), {6'd0, bus.out_digit}, {6'd0, e});
      chk($sformatf("first_%0h_d%0d", v.data, k), {7'd0, bus.out_first}, {7'd0, k == 0});
      chk($sformatf("last_%0h_d%0d", v.data, k), {7'd0, bus.out_last}, {7'd0, k == FL-1});
      chk($sformatf("busy_%0h_d%0d", v.data, k), {7'd0, busy}, 8'd1);
      if (k == stall_at) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h55;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          chk($sformatf("stall_ready_s%0d", s), {7'd0, bus.in_ready}, 8'd0);
          @(negedge clk);
          chk($sformatf("stall_valid_s%0d", s), {7'd0, bus.out_valid}, 8'd1);
          chk($sformatf("stall_digit_s%0d", s), {6'd0, bus.out_digit}, {6'd0, e});
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        #1;
      end
      chk($sformatf("in_ready_%0h_d%0d", v.data, k), {7'd0, bus.in_ready}, {7'd0, k == FL-1});
      @(negedge clk);
    end
    if (!has_next) begin
      chk($sformatf("end_valid_%0h", v.data), {7'd0, bus.out_valid}, 8'd0);
      chk($sformatf("end_busy_%0h", v.data), {7'd0, busy}, 8'd0);
      chk($sformatf("end_ready_%0h", v.data), {7'd0, bus.in_ready}, 8'd1);
    end
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = '{8'hA0, {M, Z, P, Z, Z, Z, Z, Z}};
    tbl[1] = '{8'h60, {Z, P, P, Z, Z, Z, Z, Z}};
    tbl[2] = '{8'hC0, {M, P, Z, Z, Z, Z, Z, Z}};
    tbl[3] = '{8'hC3, {M, P, Z, Z, Z, Z, P, P}};
    tbl[4] = '{8'h7F, {Z, P, P, P, P, P, P, P}};
    tbl[5] = '{8'h01, {Z, Z, Z, Z, Z, Z, Z, P}};
    tbl[6] = '{8'h80, {M, Z, Z, Z, Z, Z, Z, Z}};
    tbl[7] = '{8'hFF, {M, P, P, P, P, P, P, P}};

    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("rst_ready", {7'd0, bus.in_ready}, 8'd1);
    chk("rst_busy",  {7'd0, busy}, 8'd0);
    chk("rst_digit", {6'd0, bus.out_digit}, {6'd0, Z});
    chk("rst_first", {7'd0, bus.out_first}, 8'd0);
    chk("rst_last",  {7'd0, bus.out_last}, 8'd0);
    rst = 1'b1;
    @(negedge clk);

    // Table-driven single frames, out_ready held high
    for (int i = 0; i < 7; i++) begin
      accept(tbl[i].data);
      stream(tbl[i], -1, 0, 1'b0, 8'h00);
      @(negedge clk);
    end

    // Backpressure: 3-cycle stall at digit 2 of 8'hFF
    accept(tbl[7].data);
    stream(tbl[7], 2, 3, 1'b0, 8'h00);

    // Back-to-back: 8'h80 then 8'h01 with in_valid held high
    accept(tbl[6].data);
    stream(tbl[6], -1, 0, 1'b1, tbl[5].data);
    stream(tbl[5], -1, 0, 1'b0, 8'h00);

    // Reset mid-frame at digit 4, then a clean frame of 8'h40
    accept(8'hFF);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_digit4", {6'd0, bus.out_digit}, {6'd0, P});
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {7'd0, bus.out_valid}, 8'd0);
    chk("mid_rst_busy",  {7'd0, busy}, 8'd0);
    chk("mid_rst_first", {7'd0, bus.out_first}, 8'd0);
    chk("mid_rst_last",  {7'd0, bus.out_last}, 8'd0);
    chk("mid_rst_ready", {7'd0, bus.in_ready}, 8'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", {7'd0, bus.out_valid}, 8'd0);
    accept(8'h40);
    stream('{8'h40, {Z, P, Z, Z, Z, Z, Z, Z}}, -1, 0, 1'b0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
